// File: rtl/nock_mem_pkg.sv
// Shared constants and types for the NockPU noun word store.
package nock_mem_pkg;

  localparam int unsigned NOCK_DATA_W = 69;
  localparam int unsigned NOCK_ADDR_W = 10;

  // Noun word layout: tag in the MSBs, then head, then tail in the LSBs
  localparam int unsigned NOCK_TAIL_LSB = 0;
  localparam int unsigned NOCK_TAIL_W   = 32;
  localparam int unsigned NOCK_HEAD_LSB = NOCK_TAIL_LSB + NOCK_TAIL_W;
  localparam int unsigned NOCK_HEAD_W   = 32;
  localparam int unsigned NOCK_TAG_LSB  = NOCK_HEAD_LSB + NOCK_HEAD_W;
  localparam int unsigned NOCK_TAG_W    = NOCK_DATA_W - NOCK_TAG_LSB;

  typedef struct packed {
    logic                   we;
    logic [NOCK_ADDR_W-1:0] addr;
    logic [NOCK_DATA_W-1:0] data;
  } mem_req_t;

  function automatic logic [NOCK_TAG_W-1:0] noun_tag(input logic [NOCK_DATA_W-1:0] word);
    return word[NOCK_TAG_LSB +: NOCK_TAG_W];
  endfunction

  function automatic logic [NOCK_HEAD_W-1:0] noun_head(input logic [NOCK_DATA_W-1:0] word);
    return word[NOCK_HEAD_LSB +: NOCK_HEAD_W];
  endfunction

  function automatic logic [NOCK_TAIL_W-1:0] noun_tail(input logic [NOCK_DATA_W-1:0] word);
    return word[NOCK_TAIL_LSB +: NOCK_TAIL_W];
  endfunction

endpackage

// File: rtl/ram_core.sv
// Plain single-port inferred block RAM; the array is never reset so contents
// survive a reset of the surrounding logic.
module ram_core
  import nock_mem_pkg::*;
#(
  parameter int unsigned DATA_W = NOCK_DATA_W,
  parameter int unsigned ADDR_W = NOCK_ADDR_W
) (
  input  logic              clock,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wren,
  output logic [DATA_W-1:0] q
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Read-old-data on a write cycle; callers only consume q after reads
  always_ff @(posedge clock) begin
    if (wren) begin
      mem[addr] <= wdata;
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter in front of a single-port noun store, returning tagged
// fixed-latency responses to each requester.
module ram_arbiter
  import nock_mem_pkg::*;
#(
  parameter int unsigned DATA_W   = NOCK_DATA_W,
  parameter int unsigned ADDR_W   = NOCK_ADDR_W,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned OUT_REG  = 0
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [CHANNELS-1:0]          req_valid,
  output logic [CHANNELS-1:0]          req_ready,
  input  logic [CHANNELS-1:0]          req_we,
  input  logic [CHANNELS*ADDR_W-1:0]   req_addr,
  input  logic [CHANNELS*DATA_W-1:0]   req_data,
  output logic [CHANNELS-1:0]          rsp_valid,
  output logic                         rsp_we,
  output logic [DATA_W-1:0]            rsp_data
);

  localparam int unsigned PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [PTR_W-1:0]    rr_q, rr_d;
  logic [PTR_W-1:0]    gnt_idx;
  logic [PTR_W-1:0]    cand;
  logic                gnt_any;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic [DATA_W-1:0]   rd_q;
  logic [CHANNELS-1:0] s1_ch_q, s1_ch_d;
  logic                s1_we_q, s1_we_d;
  logic                rd_hit;

  // First valid channel at or after the pointer wins; nothing granted in reset
  always_comb begin
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    req_ready = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      cand = PTR_W'((32'(rr_q) + i) % CHANNELS);
      if (!gnt_any && req_valid[cand] && reset_n) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    req_ready[gnt_idx] = gnt_any;
  end

  always_comb begin
    sel_we   = req_we[gnt_idx];
    sel_addr = req_addr[32'(gnt_idx) * ADDR_W +: ADDR_W];
    sel_data = req_data[32'(gnt_idx) * DATA_W +: DATA_W];
    rr_d     = gnt_any ? PTR_W'((32'(gnt_idx) + 1) % CHANNELS) : rr_q;
    s1_ch_d  = req_ready;
    s1_we_d  = gnt_any & sel_we;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_q    <= '0;
      s1_ch_q <= '0;
      s1_we_q <= 1'b0;
    end else begin
      rr_q    <= rr_d;
      s1_ch_q <= s1_ch_d;
      s1_we_q <= s1_we_d;
    end
  end

  ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram_core (
    .clock (clock),
    .addr  (sel_addr),
    .wdata (sel_data),
    .wren  (gnt_any & sel_we),
    .q     (rd_q)
  );

  assign rd_hit = (|s1_ch_q) & ~s1_we_q;

  if (OUT_REG != 0) begin : g_out_reg
    logic [CHANNELS-1:0] s2_ch_q;
    logic                s2_we_q;
    logic [DATA_W-1:0]   data_q, data_d;

    always_comb begin
      data_d = rd_hit ? rd_q : data_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        s2_ch_q <= '0;
        s2_we_q <= 1'b0;
        data_q  <= '0;
      end else begin
        s2_ch_q <= s1_ch_q;
        s2_we_q <= s1_we_q;
        data_q  <= data_d;
      end
    end

    assign rsp_valid = s2_ch_q;
    assign rsp_we    = s2_we_q;
    assign rsp_data  = data_q;
  end else begin : g_no_out_reg
    // RAM output is already registered; the hold flop keeps the last read value
    logic [DATA_W-1:0] hold_q, hold_d;

    always_comb begin
      hold_d = rd_hit ? rd_q : hold_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        hold_q <= '0;
      end else begin
        hold_q <= hold_d;
      end
    end

    assign rsp_valid = s1_ch_q;
    assign rsp_we    = s1_we_q;
    assign rsp_data  = hold_d;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench: two-channel latency-1 instance driven from a vector table,
// four-channel latency-2 instance exercised by hand-written sequences.
module tb_ram_arbiter;

  localparam int DW = 69;
  localparam int AW = 10;

  localparam logic [DW-1:0] D1 = 69'h1_2345_6789_ABCD_EF01;
  localparam logic [DW-1:0] D2 = 69'h0_DEAD_BEEF_0000_1111;
  localparam logic [DW-1:0] D3 = 69'h1F_FFFF_FFFF_FFFF_FFFF;
  localparam logic [DW-1:0] D4 = 69'h0A_5A5A_5A5A_5A5A_5A5A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Two-channel, OUT_REG=0 instance
  logic          rst_n;
  logic [1:0]    valid2, we2, rdy2, rv2;
  logic [2*AW-1:0] addr2;
  logic [2*DW-1:0] data2;
  logic          rwe2;
  logic [DW-1:0] rdata2;

  ram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CHANNELS(2), .OUT_REG(0)) u_dut (
    .clock(clk), .reset_n(rst_n),
    .req_valid(valid2), .req_ready(rdy2), .req_we(we2),
    .req_addr(addr2), .req_data(data2),
    .rsp_valid(rv2), .rsp_we(rwe2), .rsp_data(rdata2)
  );

  // Four-channel, OUT_REG=1 instance
  logic          rst4_n;
  logic [3:0]    valid4, we4, rdy4, rv4;
  logic [4*AW-1:0] addr4;
  logic [4*DW-1:0] data4;
  logic          rwe4;
  logic [DW-1:0] rdata4;

  ram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CHANNELS(4), .OUT_REG(1)) u_dut4 (
    .clock(clk), .reset_n(rst4_n),
    .req_valid(valid4), .req_ready(rdy4), .req_we(we4),
    .req_addr(addr4), .req_data(data4),
    .rsp_valid(rv4), .rsp_we(rwe4), .rsp_data(rdata4)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]    valid;
    logic [1:0]    we;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [1:0]    exp_rdy;
    logic [1:0]    exp_rv;
    logic          exp_we;
    logic          chk_data;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic [1:0] v, input logic [1:0] w,
                              input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                              input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                              input logic [1:0] rdy, input logic [1:0] rv,
                              input logic ewe, input logic cd, input logic [DW-1:0] ed);
    vec_t r;
    r.valid = v; r.we = w; r.a0 = a0; r.a1 = a1; r.d0 = d0; r.d1 = d1;
    r.exp_rdy = rdy; r.exp_rv = rv; r.exp_we = ewe; r.chk_data = cd; r.exp_data = ed;
    return r;
  endfunction

  initial begin
    // Pointer evolution noted per row as "ptr before -> after"
    vt.push_back(mk(2'b01, 2'b01,    5,  0, D1, '0, 2'b01, 2'b01, 1'b1, 1'b0, '0)); // 0->1 ch0 wr
    vt.push_back(mk(2'b01, 2'b00,    5,  0, '0, '0, 2'b01, 2'b01, 1'b0, 1'b1, D1)); // 1->1 ch0 rd
    vt.push_back(mk(2'b10, 2'b10,    0,  7, '0, D2, 2'b10, 2'b10, 1'b1, 1'b0, '0)); // 1->0 ch1 wr
    vt.push_back(mk(2'b10, 2'b10,    0,  0, '0, D4, 2'b10, 2'b10, 1'b1, 1'b0, '0)); // 0->0 ch1 wr
    vt.push_back(mk(2'b11, 2'b00,    5,  7, '0, '0, 2'b01, 2'b01, 1'b0, 1'b1, D1)); // contention
    vt.push_back(mk(2'b11, 2'b00,    5,  7, '0, '0, 2'b10, 2'b10, 1'b0, 1'b1, D2));
    vt.push_back(mk(2'b11, 2'b00,    5,  7, '0, '0, 2'b01, 2'b01, 1'b0, 1'b1, D1));
    vt.push_back(mk(2'b11, 2'b00,    5,  7, '0, '0, 2'b10, 2'b10, 1'b0, 1'b1, D2));
    vt.push_back(mk(2'b11, 2'b00,    5,  7, '0, '0, 2'b01, 2'b01, 1'b0, 1'b1, D1));
    vt.push_back(mk(2'b11, 2'b00,    5,  7, '0, '0, 2'b10, 2'b10, 1'b0, 1'b1, D2)); // ->0
    vt.push_back(mk(2'b01, 2'b01, 1023,  0, D3, '0, 2'b01, 2'b01, 1'b1, 1'b0, '0)); // 0->1 wr 1023
    vt.push_back(mk(2'b01, 2'b00, 1023,  0, '0, '0, 2'b01, 2'b01, 1'b0, 1'b1, D3)); // rd 1023 next
    vt.push_back(mk(2'b10, 2'b00,    0,  0, '0, '0, 2'b10, 2'b10, 1'b0, 1'b1, D4)); // 1->0 rd addr 0
    vt.push_back(mk(2'b00, 2'b00,    0,  0, '0, '0, 2'b00, 2'b00, 1'b0, 1'b1, D4)); // idle, hold data
    vt.push_back(mk(2'b11, 2'b00, 1023,  7, '0, '0, 2'b01, 2'b01, 1'b0, 1'b1, D3)); // ptr kept 0
    vt.push_back(mk(2'b11, 2'b00, 1023,  7, '0, '0, 2'b10, 2'b10, 1'b0, 1'b1, D2));

    // Reset held three cycles with every request valid
    rst_n = 1'b0; rst4_n = 1'b0;
    valid2 = 2'b11; we2 = 2'b00; addr2 = '0; data2 = '0;
    valid4 = 4'b1111; we4 = 4'b0000; addr4 = '0; data4 = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rst_ready2_c%0d", c), DW'(rdy2), '0);
      chk($sformatf("rst_rspvalid2_c%0d", c), DW'(rv2), '0);
      chk($sformatf("rst_ready4_c%0d", c), DW'(rdy4), '0);
      chk($sformatf("rst_rspvalid4_c%0d", c), DW'(rv4), '0);
    end
    chk("rst_rsp_we", DW'(rwe2), '0);
    chk("rst_rsp_data", rdata2, '0);
    rst_n = 1'b1; rst4_n = 1'b1;
    #1;
    chk("post_rst_ch0_first2", DW'(rdy2), DW'(2'b01));
    chk("post_rst_ch0_first4", DW'(rdy4), DW'(4'b0001));
    valid2 = 2'b00; valid4 = 4'b0000;

    // Table-driven two-channel run
    @(negedge clk);
    for (int i = 0; i < vt.size(); i++) begin
      valid2 = vt[i].valid;
      we2    = vt[i].we;
      addr2  = {vt[i].a1, vt[i].a0};
      data2  = {vt[i].d1, vt[i].d0};
      #1;
      chk($sformatf("v%0d_ready", i), DW'(rdy2), DW'(vt[i].exp_rdy));
      @(negedge clk);
      chk($sformatf("v%0d_rsp_valid", i), DW'(rv2), DW'(vt[i].exp_rv));
      if (vt[i].exp_rv != 2'b00) chk($sformatf("v%0d_rsp_we", i), DW'(rwe2), DW'(vt[i].exp_we));
      if (vt[i].chk_data) chk($sformatf("v%0d_rsp_data", i), rdata2, vt[i].exp_data);
    end
    valid2 = 2'b00;

    // Four-channel, latency 2: ch1 write, pointer moves to 2
    @(negedge clk);
    valid4 = 4'b0010; we4 = 4'b0010;
    addr4[1*AW +: AW] = 10'd9; data4[1*DW +: DW] = D2;
    #1 chk("c4_wr_ready", DW'(rdy4), DW'(4'b0010));
    @(negedge clk);
    chk("c4_wr_lat1", DW'(rv4), '0);
    // ch3 and ch1 valid with pointer at 2: ch3 first, then ch1
    valid4 = 4'b1010; we4 = 4'b0000;
    addr4[3*AW +: AW] = 10'd9;
    #1 chk("c4_ptr2_ready", DW'(rdy4), DW'(4'b1000));
    @(negedge clk);
    chk("c4_wr_ack_valid", DW'(rv4), DW'(4'b0010));
    chk("c4_wr_ack_we", DW'(rwe4), DW'(1'b1));
    chk("c4_then_ch1", DW'(rdy4), DW'(4'b0010));
    @(negedge clk);
    valid4 = 4'b0000;
    chk("c4_rsp_ch3_valid", DW'(rv4), DW'(4'b1000));
    chk("c4_rsp_ch3_we", DW'(rwe4), '0);
    chk("c4_rsp_ch3_data", rdata4, D2);
    @(negedge clk);
    chk("c4_rsp_ch1_valid", DW'(rv4), DW'(4'b0010));
    chk("c4_rsp_ch1_data", rdata4, D2);

    // Read accepted, then reset before its response appears
    valid4 = 4'b0001; addr4[0 +: AW] = 10'd9;
    #1 chk("c4_mid_ready", DW'(rdy4), DW'(4'b0001));
    @(negedge clk);
    chk("c4_mid_lat1", DW'(rv4), '0);
    valid4 = 4'b0000;
    rst4_n = 1'b0;
    #1 chk("c4_mid_rst_valid", DW'(rv4), '0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("c4_mid_dropped_c%0d", c), DW'(rv4), '0);
      chk($sformatf("c4_mid_data0_c%0d", c), rdata4, '0);
    end
    rst4_n = 1'b1;
    @(negedge clk);
    chk("c4_after_rst_idle", DW'(rv4), '0);
    // Memory persists across reset
    valid4 = 4'b0100; addr4[2*AW +: AW] = 10'd9;
    #1 chk("c4_persist_ready", DW'(rdy4), DW'(4'b0100));
    @(negedge clk);
    valid4 = 4'b0000;
    chk("c4_persist_lat1", DW'(rv4), '0);
    @(negedge clk);
    chk("c4_persist_valid", DW'(rv4), DW'(4'b0100));
    chk("c4_persist_data", rdata4, D2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
